// File: rtl/if_id_latch.sv
// ============================================================================
//  Module      : if_id_latch
//  Description : IF/ID pipeline register for the 16-bit WISC pipeline.
//                Captures the fetched instruction and PC+2 each cycle and
//                presents them to decode. Supports stall (hold), flush
//                (bubble injection) and sticky HALT detection, drives a
//                hold request back to the fetch PC logic, and keeps a
//                saturating stall-cycle counter for performance debug.
//
//  Ports       :
//    clk          in   1      system clock, rising-edge active
//    rst          in   1      synchronous active-high reset
//    instr_in     in   WIDTH  instruction word from fetch
//    pc_next_in   in   WIDTH  PC+2 from fetch
//    stall        in   1      hazard unit hold request
//    flush        in   1      branch/jump redirect, kills the capture
//    instr_out    out  WIDTH  registered instruction to decode
//    pc_next_out  out  WIDTH  registered PC+2 to decode
//    valid_out    out  1      instr_out is a real instruction
//    halt_out     out  1      sticky: a HALT has been captured
//    fetch_hold   out  1      fetch must not advance PC this cycle
//    stall_cnt    out  16     saturating stall-cycle counter
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_latch #(
    parameter int          WIDTH       = 16,
    parameter logic [15:0] NOP_INSTR   = 16'h0800,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [WIDTH-1:0] pc_next_in,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_next_out,
    output logic             valid_out,
    output logic             halt_out,
    output logic             fetch_hold,
    output logic [15:0]      stall_cnt
);

    // ------------------------------------------------------------------
    // State encoding. HALTED is split into two encodings so the HALT word
    // reaches decode for exactly one cycle: HALT_NEW is the cycle the HALT
    // is visible on instr_out, HALT_HOLD is every cycle after the bubble
    // has replaced it. Both encodings share bit 1, which is what the
    // fetch hold decode uses.
    // ------------------------------------------------------------------
    localparam logic [1:0] c_st_empty     = 2'b00;
    localparam logic [1:0] c_st_run       = 2'b01;
    localparam logic [1:0] c_st_halt_new  = 2'b10;
    localparam logic [1:0] c_st_halt_hold = 2'b11;

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;

    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc_next;
    logic             r_valid;
    logic             r_halt;
    logic [15:0]      r_stall_cnt;

    logic             w_halted;
    logic             w_is_halt;
    logic             w_live;
    logic             w_do_stall;
    logic             w_do_capture;

    // Both halted encodings count as the HALTED state.
    assign w_halted  = r_state[1];
    assign w_is_halt = (instr_in[WIDTH-1:WIDTH-5] == HALT_OPCODE);

    // EMPTY or RUN: the only states where stall and capture apply.
    assign w_live       = ~w_halted;
    assign w_do_stall   = ~flush & stall & w_live;
    assign w_do_capture = ~flush & ~stall & w_live;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority: flush > stall > capture. A flush out of
    // HALTED is legal because a HALT behind a taken branch is speculative.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = c_st_empty;
        end else begin
            case (r_state)
                c_st_empty,
                c_st_run: begin
                    if (!stall) begin
                        w_state_next = w_is_halt ? c_st_halt_new : c_st_run;
                    end
                end
                c_st_halt_new: begin
                    w_state_next = c_st_halt_hold;
                end
                c_st_halt_hold: begin
                    w_state_next = c_st_halt_hold;
                end
                default: begin
                    w_state_next = c_st_empty;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr   <= NOP_INSTR[WIDTH-1:0];
            r_pc_next <= '0;
            r_valid   <= 1'b0;
            r_halt    <= 1'b0;
        end else if (flush) begin
            // Bubble injection; PC+2 is left alone.
            r_instr <= NOP_INSTR[WIDTH-1:0];
            r_valid <= 1'b0;
            r_halt  <= 1'b0;
        end else if (w_do_capture) begin
            r_instr   <= instr_in;
            r_pc_next <= pc_next_in;
            r_valid   <= 1'b1;
            if (w_is_halt) begin
                r_halt <= 1'b1;
            end
        end else if (r_state == c_st_halt_new) begin
            // Retire the HALT word from decode after its single cycle.
            r_instr <= NOP_INSTR[WIDTH-1:0];
            r_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle counter: counts only stalls that actually hold the
    // register (not flushed, not halted) and saturates instead of wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_do_stall && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instr_out   = r_instr;
    assign pc_next_out = r_pc_next;
    assign valid_out   = r_valid;
    assign halt_out    = r_halt;
    assign stall_cnt   = r_stall_cnt;

    // Combinational so fetch freezes in the same cycle the stall appears.
    assign fetch_hold  = stall | w_halted;

endmodule

`default_nettype wire

// File: tb/tb_if_id_latch.sv
// ============================================================================
//  Module      : tb_if_id_latch
//  Description : Directed self-checking bench for if_id_latch.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_id_latch;

    logic        clk;
    logic        rst;
    logic [15:0] instr_in;
    logic [15:0] pc_next_in;
    logic        stall;
    logic        flush;
    logic [15:0] instr_out;
    logic [15:0] pc_next_out;
    logic        valid_out;
    logic        halt_out;
    logic        fetch_hold;
    logic [15:0] stall_cnt;

    int n_checks;
    int n_pass;

    if_id_latch #(
        .WIDTH       (16),
        .NOP_INSTR   (16'h0800),
        .HALT_OPCODE (5'b00000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .pc_next_in  (pc_next_in),
        .stall       (stall),
        .flush       (flush),
        .instr_out   (instr_out),
        .pc_next_out (pc_next_out),
        .valid_out   (valid_out),
        .halt_out    (halt_out),
        .fetch_hold  (fetch_hold),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst        = 1'b1;
        stall      = 1'b0;
        flush      = 1'b0;
        instr_in   = 16'h1111;
        pc_next_in = 16'h0abc;

        // ---- reset for two cycles
        step();
        step();
        check("rst_instr",  instr_out,   16'h0800);
        check("rst_valid",  {15'd0, valid_out},  16'd0);
        check("rst_pc",     pc_next_out, 16'h0000);
        check("rst_halt",   {15'd0, halt_out},   16'd0);
        check("rst_cnt",    stall_cnt,   16'h0000);
        check("rst_hold",   {15'd0, fetch_hold}, 16'd0);

        // ---- first capture
        rst        = 1'b0;
        instr_in   = 16'h4123;
        pc_next_in = 16'h0002;
        step();
        check("cap_instr", instr_out,   16'h4123);
        check("cap_pc",    pc_next_out, 16'h0002);
        check("cap_valid", {15'd0, valid_out}, 16'd1);

        // ---- stall holds for three edges
        stall      = 1'b1;
        instr_in   = 16'h5555;
        pc_next_in = 16'h0004;
        #1;
        check("stall_hold_comb", {15'd0, fetch_hold}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", instr_out,   16'h4123);
            check("stall_pc",    pc_next_out, 16'h0002);
            check("stall_hold",  {15'd0, fetch_hold}, 16'd1);
        end
        check("stall_cnt3", stall_cnt, 16'd3);

        // ---- flush beats stall
        flush = 1'b1;
        step();
        check("flush_instr", instr_out,   16'h0800);
        check("flush_valid", {15'd0, valid_out}, 16'd0);
        check("flush_pc",    pc_next_out, 16'h0002);
        check("flush_cnt",   stall_cnt,   16'd3);

        // ---- halt sequence
        flush      = 1'b0;
        stall      = 1'b0;
        instr_in   = 16'h0000;
        pc_next_in = 16'h0010;
        step();
        check("halt1_instr", instr_out,   16'h0000);
        check("halt1_valid", {15'd0, valid_out},  16'd1);
        check("halt1_halt",  {15'd0, halt_out},   16'd1);
        check("halt1_hold",  {15'd0, fetch_hold}, 16'd1);
        check("halt1_pc",    pc_next_out, 16'h0010);
        instr_in   = 16'h7777;
        pc_next_in = 16'h0020;
        step();
        check("halt2_instr", instr_out,   16'h0800);
        check("halt2_valid", {15'd0, valid_out}, 16'd0);
        check("halt2_halt",  {15'd0, halt_out},  16'd1);
        check("halt2_pc",    pc_next_out, 16'h0010);
        stall = 1'b1;
        step();
        check("halt3_instr", instr_out,   16'h0800);
        check("halt3_pc",    pc_next_out, 16'h0010);
        check("halt3_cnt",   stall_cnt,   16'd3);
        stall = 1'b0;
        #1;
        check("halt3_hold",  {15'd0, fetch_hold}, 16'd1);

        // ---- flush out of HALTED
        flush = 1'b1;
        step();
        check("unhalt_halt",  {15'd0, halt_out},   16'd0);
        check("unhalt_valid", {15'd0, valid_out},  16'd0);
        check("unhalt_hold",  {15'd0, fetch_hold}, 16'd0);
        flush      = 1'b0;
        instr_in   = 16'h6A01;
        pc_next_in = 16'h0030;
        step();
        check("recap_instr", instr_out,   16'h6A01);
        check("recap_valid", {15'd0, valid_out}, 16'd1);
        check("recap_pc",    pc_next_out, 16'h0030);

        // ---- counter saturation
        stall    = 1'b1;
        instr_in = 16'h9999;
        for (int i = 0; i < 65537; i++) begin
            step();
        end
        check("sat_cnt", stall_cnt, 16'hFFFF);
        step();
        step();
        check("sat_cnt_hold", stall_cnt, 16'hFFFF);
        check("sat_instr",    instr_out, 16'h6A01);

        // ---- reset during stall
        rst = 1'b1;
        step();
        check("mrst_cnt",   stall_cnt,   16'h0000);
        check("mrst_instr", instr_out,   16'h0800);
        check("mrst_valid", {15'd0, valid_out}, 16'd0);
        check("mrst_pc",    pc_next_out, 16'h0000);
        rst   = 1'b0;
        stall = 1'b0;
        #1;
        check("mrst_hold", {15'd0, fetch_hold}, 16'd0);
        instr_in   = 16'h2345;
        pc_next_in = 16'h0042;
        step();
        check("post_instr", instr_out, 16'h2345);
        check("post_halt",  {15'd0, halt_out}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
